fifo_reader: RTL and testbench
==============================

FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 6, word width, matching the FIFO data width.
REQ-002 SHALL have parameter CNT_W, default 16, width of the read counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port enable  input  1  1 = drain FIFO; 0 = stop issuing reads.
REQ-006 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-007 SHALL have port fifo_data  input  DATA_W  FIFO data_out, valid the cycle after fifo_rd.
REQ-008 SHALL have port fifo_rd  output  1  FIFO read strobe, one word per high cycle.
REQ-009 SHALL have port out_data  output  DATA_W  head word to downstream.
REQ-010 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the word this cycle.
REQ-012 SHALL have port rd_count  output  CNT_W  total fifo_rd pulses since reset.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, ACTIVE, DRAIN in a registered state machine.
REQ-015 SHALL go IDLE->ACTIVE when enable=1; ACTIVE->DRAIN when enable=0; DRAIN->ACTIVE when enable=1.
REQ-016 SHALL go DRAIN->IDLE when enable=0, no read in flight, and buffer occupancy is 0.
REQ-017 SHALL hold a 2-entry output buffer, first-in first-out; out_data = oldest entry, out_valid = (occupancy>0).
REQ-018 SHALL define pop = out_valid && out_ready; popped entry leaves the buffer at the clock edge.
REQ-019 SHALL assert fifo_rd combinationally iff state=ACTIVE && !fifo_empty && (occupancy + inflight - pop) < 2.
REQ-020 SHALL register inflight = fifo_rd; when inflight=1, fifo_data SHALL be written to the buffer tail at that edge (1-cycle read latency).
REQ-021 SHALL, on simultaneous capture and pop, keep occupancy unchanged and preserve order (the captured word follows the remaining entry).
REQ-022 SHALL never capture into a full buffer; the credit rule of REQ-019 guarantees this.
REQ-023 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-024 SHALL sustain one word per cycle with out_ready held 1 and FIFO non-empty.
REQ-025 SHALL issue no new fifo_rd in DRAIN or IDLE; in-flight words SHALL still be captured and delivered in DRAIN.
REQ-026 SHALL increment rd_count by 1 on every cycle fifo_rd=1, wrapping modulo 2^CNT_W.
REQ-027 SHALL keep out_valid deasserted and out_data unchanged when occupancy is 0 (no bubbles of stale data marked valid).

Reset
REQ-028 SHALL, with RESET=1 at a clock edge, set state=IDLE, occupancy=0, inflight=0, rd_count=0, out_data=0.
REQ-029 SHALL hold fifo_rd=0, out_valid=0, busy=0 during and immediately after reset.
REQ-030 SHALL discard any buffered or in-flight word on reset mid-operation; RESET SHALL take priority over all other inputs.

Verification
REQ-031 Reset: RESET=1 one cycle, enable=1, FIFO non-empty -> fifo_rd=0, out_valid=0, rd_count=0, busy=0 that cycle; fifo_rd=1 the cycle after release.
REQ-032 Streaming: FIFO preloaded 0x01..0x08, enable=1, out_ready=1 -> out_data 0x01..0x08 on 8 consecutive out_valid cycles starting 2 cycles after first fifo_rd; rd_count=8.
REQ-033 Backpressure: out_ready=0 with 5 words queued -> exactly 2 fifo_rd pulses, out_data=first word held stable; out_ready=1 -> remaining 3 words delivered in order, no loss or duplicate.
REQ-034 Empty boundary: FIFO holds 1 word (0x2A) -> single fifo_rd, out_data=0x2A once; fifo_rd stays 0 while fifo_empty=1.
REQ-035 Drain: enable dropped in the same cycle as fifo_rd=1 -> state DRAIN, in-flight word still delivered, no further fifo_rd, busy falls the cycle after the last pop.
REQ-036 Wrap: CNT_W=4, 17 reads -> rd_count=1.

Source files
------------

// File: rtl/fifo_reader.sv
// fifo_reader: drains a 1-cycle-latency FIFO into a 2-entry output buffer
// with a valid/ready downstream port, credit-limited so the buffer never overflows.
module fifo_reader #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  rd_count,
  output logic              busy
);

  localparam int unsigned OCC_W  = 2;
  localparam int unsigned CRED_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [OCC_W-1:0]   occ;
  logic               inflight;
  logic [DATA_W-1:0]  buf_head;
  logic [DATA_W-1:0]  buf_tail;
  logic [CNT_W-1:0]   rd_cnt_q;

  logic               pop;
  logic [CRED_W-1:0]  committed;

  // Downstream view of the buffer; reset masks everything visible
  assign out_valid = !RESET && (occ != OCC_W'(0));
  assign out_data  = buf_head;
  assign rd_count  = rd_cnt_q;
  assign pop       = out_valid && out_ready;

  // Words owned after this edge: buffered + in flight - leaving now
  assign committed = CRED_W'(occ) + CRED_W'(inflight) - CRED_W'(pop);

  // State register
  always_ff @(posedge clk) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; DRAIN waits for the pipeline and buffer to empty
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!enable) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (enable) begin
          state_next = ACTIVE;
        end else if (!inflight && (occ == OCC_W'(0))) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM outputs; a read is issued only while a buffer slot is guaranteed free
  always_comb begin
    fifo_rd = 1'b0;
    busy    = 1'b0;
    if (!RESET) begin
      busy    = (state != IDLE);
      fifo_rd = (state == ACTIVE) && !fifo_empty && (committed < CRED_W'(2));
    end
  end

  // Read pipeline stage and read counter
  always_ff @(posedge clk) begin
    if (RESET) begin
      inflight <= 1'b0;
      rd_cnt_q <= '0;
    end else begin
      inflight <= fifo_rd;
      if (fifo_rd) begin
        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      end
    end
  end

  // Two-entry output buffer: capture at tail, pop from head, order preserved
  always_ff @(posedge clk) begin
    if (RESET) begin
      occ      <= '0;
      buf_head <= '0;
      buf_tail <= '0;
    end else begin
      case ({inflight, pop})
        2'b01: begin
          // Pop only; head keeps its old value when the buffer empties
          if (occ == OCC_W'(2)) begin
            buf_head <= buf_tail;
          end
          occ <= occ - OCC_W'(1);
        end
        2'b10: begin
          // Capture only; credit rule guarantees occ < 2 here
          if (occ == OCC_W'(0)) begin
            buf_head <= fifo_data;
          end else begin
            buf_tail <= fifo_data;
          end
          occ <= occ + OCC_W'(1);
        end
        2'b11: begin
          // Capture and pop together; new word lands behind the survivor
          if (occ == OCC_W'(1)) begin
            buf_head <= fifo_data;
          end else begin
            buf_head <= buf_tail;
            buf_tail <= fifo_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed stimulus into a FIFO model, scoreboard on the output port.
module tb_fifo_reader;

  localparam int unsigned DATA_W = 6;

  logic              clk;
  logic              RESET;
  logic              enable;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              out_ready;

  logic              fifo_rd;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [15:0]       rd_count;
  logic              busy;

  logic              fifo_rd4;
  logic [DATA_W-1:0] out_data4;
  logic              out_valid4;
  logic [3:0]        rd_count4;
  logic              busy4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] exp_q[$];

  fifo_reader #(.DATA_W(DATA_W), .CNT_W(16)) dut (
    .clk(clk), .RESET(RESET), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd(fifo_rd), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .rd_count(rd_count), .busy(busy)
  );

  // Narrow-counter copy in lockstep for the wrap check
  fifo_reader #(.DATA_W(DATA_W), .CNT_W(4)) dut4 (
    .clk(clk), .RESET(RESET), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_rd(fifo_rd4), .out_data(out_data4),
    .out_valid(out_valid4), .out_ready(out_ready), .rd_count(rd_count4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model with one-cycle read latency
  logic [DATA_W-1:0] mem [0:63];
  int rptr = 0;
  int wptr = 0;
  assign fifo_empty = (rptr == wptr);

  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_data <= mem[rptr[5:0]];
      rptr      <= rptr + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Word that must come out downstream
  task automatic load(input logic [DATA_W-1:0] w);
    mem[wptr[5:0]] = w;
    wptr = wptr + 1;
    exp_q.push_back(w);
  endtask

  // Word expected to be discarded by a reset
  task automatic load_nx(input logic [DATA_W-1:0] w);
    mem[wptr[5:0]] = w;
    wptr = wptr + 1;
  endtask

  // Scoreboard monitor: compares every accepted word, checks hold stability
  logic              prev_hold = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  logic [DATA_W-1:0] exp_w;

  always @(negedge clk) begin
    #1;
    if (!RESET) begin
      if (prev_hold) begin
        check("hold_stable", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          exp_w = exp_q.pop_front();
          check("out_word", 32'(out_data), 32'(exp_w));
        end
      end
    end
    prev_hold = !RESET && out_valid && !out_ready;
    prev_data = out_data;
  end

  int n_rd;

  initial begin
    RESET     = 1'b1;
    enable    = 1'b1;
    out_ready = 1'b1;
    load(6'h11); load(6'h12); load(6'h13);

    // Reset with enable high and FIFO non-empty
    @(negedge clk);
    check("rst_fifo_rd",   32'(fifo_rd),   32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_rd_count",  32'(rd_count),  32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    RESET = 1'b0;
    #1;
    check("post_rst_fifo_rd", 32'(fifo_rd), 32'd0);
    check("post_rst_busy",    32'(busy),    32'd0);
    @(negedge clk);
    check("first_rd_after_rel", 32'(fifo_rd), 32'd1);
    check("busy_active",        32'(busy),    32'd1);
    repeat (8) @(negedge clk);
    check("rd_count_3", 32'(rd_count), 32'd3);

    // Streaming 0x01..0x08
    for (int i = 1; i <= 8; i++) load(DATA_W'(i));
    #1;
    check("stream_first_rd", 32'(fifo_rd), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check("stream_valid", 32'(out_valid), (k >= 2 && k <= 9) ? 32'd1 : 32'd0);
    end
    check("rd_count_11", 32'(rd_count), 32'd11);

    // Backpressure: 5 words, only 2 reads while stalled
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) load(DATA_W'(8'h21 + i));
    #1;
    n_rd = int'(fifo_rd);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_rd += int'(fifo_rd);
    end
    check("bp_rd_pulses", 32'(n_rd),      32'd2);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_head",      32'(out_data),  32'h21);
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("rd_count_16", 32'(rd_count), 32'd16);

    // Single word then empty FIFO
    load(6'h2A);
    #1;
    n_rd = int'(fifo_rd);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_rd += int'(fifo_rd);
    end
    check("empty_rd_pulses", 32'(n_rd),     32'd1);
    check("rd_count_17",     32'(rd_count), 32'd17);

    // Drain: enable dropped in the same cycle as a read
    load(6'h31); load(6'h32);
    enable = 1'b0;
    #1;
    check("drain_rd_now", 32'(fifo_rd), 32'd1);
    @(negedge clk);
    check("drain1_rd",   32'(fifo_rd), 32'd0);
    check("drain1_busy", 32'(busy),    32'd1);
    @(negedge clk);
    check("drain2_rd",    32'(fifo_rd),   32'd0);
    check("drain2_busy",  32'(busy),      32'd1);
    check("drain2_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    check("drain3_rd", 32'(fifo_rd), 32'd0);
    @(negedge clk);
    check("drain4_rd",   32'(fifo_rd),  32'd0);
    check("drain4_busy", 32'(busy),     32'd0);
    check("rd_count_18", 32'(rd_count), 32'd18);
    enable = 1'b1;
    repeat (6) @(negedge clk);
    check("rd_count_19", 32'(rd_count), 32'd19);

    // Reset mid-operation discards the two buffered words
    out_ready = 1'b0;
    load_nx(6'h3A); load_nx(6'h3B); load(6'h3C); load(6'h3D);
    repeat (6) @(negedge clk);
    check("mid_valid", 32'(out_valid), 32'd1);
    check("mid_head",  32'(out_data),  32'h3A);
    RESET = 1'b1;
    @(negedge clk);
    check("mid_rst_valid",    32'(out_valid), 32'd0);
    check("mid_rst_busy",     32'(busy),      32'd0);
    check("mid_rst_rd_count", 32'(rd_count),  32'd0);
    RESET     = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("mid_rd_count_2", 32'(rd_count), 32'd2);

    // Counter wrap: 17 reads on the 4-bit instance
    RESET = 1'b1;
    @(negedge clk);
    RESET = 1'b0;
    for (int i = 0; i < 17; i++) load(DATA_W'(8'h10 + i));
    repeat (25) @(negedge clk);
    check("wrap_cnt16",     32'(rd_count),   32'd17);
    check("wrap_cnt4",      32'(rd_count4),  32'd1);
    check("wrap_last_data", 32'(out_data4),  32'h20);
    check("wrap_valid4",    32'(out_valid4), 32'd0);
    check("wrap_busy4",     32'(busy4),      32'd1);
    check("wrap_rd4",       32'(fifo_rd4),   32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
